// File: rtl/regbank_write_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_write_arbiter
//
// Shares the single write port of a four-entry bank of 4-bit enable registers
// between two requesters, A and B. At most one write is accepted per cycle.
// Contention is resolved round-robin. A requester may lock the bank for a
// burst of up to MAX_BURST transfers. Register enables and write data are
// registered and connect directly to the four register instances.
//
// Ports:
//   i_clk      rising-edge clock
//   i_reset    synchronous active-high reset
//   i_req_a    A write request          i_req_b    B write request
//   i_lock_a   A ownership request      i_lock_b   B ownership request
//   i_addr_a   A target register index  i_addr_b   B target register index
//   i_data_a   A write data             i_data_b   B write data
//   o_gnt_a    A transfer accepted      o_gnt_b    B transfer accepted
//                                       (both combinational)
//   o_en       one-hot register enables (registered), bit n -> register n
//   o_d        shared write data (registered, holds when idle)
//   o_owner    lock owner: 00 none, 01 A, 10 B (registered)
// -----------------------------------------------------------------------------
module regbank_write_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_a,
  input  logic       i_lock_a,
  input  logic [1:0] i_addr_a,
  input  logic [3:0] i_data_a,
  output logic       o_gnt_a,
  input  logic       i_req_b,
  input  logic       i_lock_b,
  input  logic [1:0] i_addr_b,
  input  logic [3:0] i_data_b,
  output logic       o_gnt_b,
  output logic [3:0] o_en,
  output logic [3:0] o_d,
  output logic [1:0] o_owner
);

  // Encodings double as the o_owner code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);
  // A burst limit of one means a lock can never outlive its first transfer.
  localparam logic       LOCK_EN = (MAX_BURST > 1) ? 1'b1 : 1'b0;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       last_b_r;      // 1: B was granted last, so A wins the next tie
  logic       last_b_nxt_s;
  logic [3:0] count_r;
  logic [3:0] count_nxt_s;
  logic [3:0] count_inc_s;
  logic       gnt_a_s;
  logic       gnt_b_s;
  logic [3:0] en_r;
  logic [3:0] en_nxt_s;
  logic [3:0] d_r;
  logic [3:0] d_nxt_s;
  logic [1:0] owner_r;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Grant decode from state, round-robin pointer and requests.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (!i_reset) begin
      case (state_r)
        IDLE: begin
          gnt_a_s = i_req_a & (~i_req_b | last_b_r);
          gnt_b_s = i_req_b & (~i_req_a | ~last_b_r);
        end
        OWN_A:   gnt_a_s = i_req_a;
        OWN_B:   gnt_b_s = i_req_b;
        default: begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      endcase
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // Next state, pointer and burst count.
  always_comb begin
    state_nxt_s  = state_r;
    last_b_nxt_s = last_b_r;
    count_nxt_s  = count_r;
    count_inc_s  = count_r + 4'd1;
    case (state_r)
      IDLE: begin
        if (gnt_a_s) begin
          last_b_nxt_s = 1'b0;
          if (i_lock_a && LOCK_EN) begin
            state_nxt_s = OWN_A;
            count_nxt_s = 4'd1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (gnt_b_s) begin
          last_b_nxt_s = 1'b1;
          if (i_lock_b && LOCK_EN) begin
            state_nxt_s = OWN_B;
            count_nxt_s = 4'd1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN_A: begin
        // Release on unlocked transfer, on hitting the cap (lock ignored),
        // or when A drops both req and lock.
        if (gnt_a_s) begin
          if (!i_lock_a || (count_inc_s == MAX_CNT)) begin
            state_nxt_s  = IDLE;
            count_nxt_s  = 4'd0;
            last_b_nxt_s = 1'b0;
          end else begin
            count_nxt_s = count_inc_s;
          end
        end else if (!i_req_a && !i_lock_a) begin
          state_nxt_s  = IDLE;
          count_nxt_s  = 4'd0;
          last_b_nxt_s = 1'b0;
        end else begin
          state_nxt_s = OWN_A;
        end
      end
      OWN_B: begin
        if (gnt_b_s) begin
          if (!i_lock_b || (count_inc_s == MAX_CNT)) begin
            state_nxt_s  = IDLE;
            count_nxt_s  = 4'd0;
            last_b_nxt_s = 1'b1;
          end else begin
            count_nxt_s = count_inc_s;
          end
        end else if (!i_req_b && !i_lock_b) begin
          state_nxt_s  = IDLE;
          count_nxt_s  = 4'd0;
          last_b_nxt_s = 1'b1;
        end else begin
          state_nxt_s = OWN_B;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = 4'd0;
      end
    endcase
  end

  // Write-port mux: enable pulses only on a transfer, data holds otherwise.
  always_comb begin
    en_nxt_s = 4'b0000;
    d_nxt_s  = d_r;
    if (gnt_a_s) begin
      en_nxt_s = onehot4(i_addr_a);
      d_nxt_s  = i_data_a;
    end else if (gnt_b_s) begin
      en_nxt_s = onehot4(i_addr_b);
      d_nxt_s  = i_data_b;
    end else begin
      en_nxt_s = 4'b0000;
      d_nxt_s  = d_r;
    end
  end

  // State and output registers; reset drops any in-flight write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= IDLE;
      last_b_r <= 1'b1;
      count_r  <= 4'd0;
      en_r     <= 4'b0000;
      d_r      <= 4'b0000;
      owner_r  <= 2'b00;
    end else begin
      state_r  <= state_nxt_s;
      last_b_r <= last_b_nxt_s;
      count_r  <= count_nxt_s;
      en_r     <= en_nxt_s;
      d_r      <= d_nxt_s;
      owner_r  <= state_nxt_s;
    end
  end

  assign o_gnt_a = gnt_a_s;
  assign o_gnt_b = gnt_b_s;
  assign o_en    = en_r;
  assign o_d     = d_r;
  assign o_owner = owner_r;

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares one write port of a four-entry bank of 4-bit enable registers between two requesters, A and B.
- Each cycle it picks at most one write. Fair default is round-robin.
- A requester may lock the bank for a burst, capped at MAX_BURST transfers.
- Drives one-hot register enables and a shared 4-bit data bus, registered, which connect directly to the bank's four enable-register instances.

Parameters:
- MAX_BURST, default 4: max consecutive transfers one locked owner may make. Legal range 1..15; MAX_BURST=1 disables lock holding.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous reset, active-high
- i_req_a  in  1  A write request
- i_lock_a  in  1  A requests ownership beyond the current transfer
- i_addr_a  in  2  A target register index
- i_data_a  in  4  A write data
- o_gnt_a  out  1  A transfer accepted this cycle
- i_req_b  in  1  B write request
- i_lock_b  in  1  B lock request
- i_addr_b  in  2  B target register index
- i_data_b  in  4  B write data
- o_gnt_b  out  1  B transfer accepted this cycle
- o_en  out  4  one-hot register enables; bit n drives register n
- o_d  out  4  shared write data to all registers
- o_owner  out  2  lock owner: 00 none, 01 A, 10 B (11 never)

Behaviour:
- Reset, synchronous and active-high, takes effect at the rising edge with i_reset=1:
  - state IDLE, o_en=0000, o_d=0000, o_owner=00, burst count 0.
  - Round-robin pointer set so A wins the first tie.
  - While i_reset=1, o_gnt_a=o_gnt_b=0 regardless of requests.
- Handshake:
  - A transfer occurs at a rising edge where req and gnt are both 1.
  - The requester holds req/lock/addr/data stable until granted.
  - Grants are combinational from state, pointer and requests. At most one grant per cycle.
- Output timing:
  - Edge after a transfer: o_en = one-hot(addr), o_d = data of the winner.
  - No transfer: o_en=0000, and o_d holds its last value.
  - The target register captures on the next edge, so request-to-register-update latency is 2 edges. Back-to-back transfers give one write per cycle.
- FSM states: IDLE, OWN_A, OWN_B.
- IDLE:
  - Single requester is granted.
  - Both requesting: grant the side not granted last (pointer), then update the pointer to the winner.
  - If the winner's lock=1 at transfer: go to OWN_winner with count=1.
  - If MAX_BURST=1, stay IDLE.
- OWN_X:
  - Only X may be granted; the other side is blocked even if X idles.
  - On each X transfer, count increments.
  - Exit to IDLE when any of these holds:
    - an X transfer with lock_X=0
    - a cycle with req_X=0 and lock_X=0
    - an X transfer that makes count == MAX_BURST (forced release, lock ignored)
  - On exit, pointer = X, so the other side wins the next tie.
- o_owner:
  - 01 in OWN_A, 10 in OWN_B, 00 in IDLE.
  - Registered, so it reflects the state after each edge.
- Address collisions are impossible (single write per cycle). Consecutive writes to the same index are legal and are not merged.
- Lock asserted with req=0 in IDLE has no effect.
- Reset mid-burst returns to IDLE next edge. A pending o_en is cleared to 0000, so the in-flight write is dropped.
- Count width is 4 bits and never wraps, since its maximum is MAX_BURST.

Test Plan:
1. Reset: i_reset=1, both req=1 -> o_gnt_a=o_gnt_b=0; after edge, o_en=0000, o_d=0000, o_owner=00.
2. Single write: A req, addr=2, data=0xA, lock=0 -> o_gnt_a=1 that cycle; next cycle o_en=0100, o_d=0xA; following cycle o_en=0000, and register 2 holds 0xA.
3. Contention: A and B request continuously, no lock, A addr 0 / B addr 3 -> grants A,B,A,B from reset; o_en alternates 0001, 1000.
4. Burst cap: MAX_BURST=4, A req+lock held, B req held -> A granted 4 consecutive cycles; o_owner=01 after cycle 1; forced release; B granted cycle 5; o_owner=00.
5. Early release: A lock, then lock=0 on 2nd transfer, B waiting -> A granted 2 cycles, B granted cycle 3. A idle-in-ownership (req=0, lock=1) keeps B blocked.
6. Reset mid-burst: i_reset=1 during OWN_B after 2 transfers -> next edge o_owner=00, o_en=0000; first post-reset tie goes to A.
